// File: rtl/furv_pkg.sv
// furv_pkg: shared types for the furv data-memory responder
package furv_pkg;
   localparam int XLEN = 32;
   typedef enum logic {IDLE, WRITE} drain_state_t;
   typedef struct packed {
      logic [XLEN-3:0] idx;
      logic [XLEN-1:0] data;
   } sbuf_entry_t;
endpackage

// File: rtl/furv_sbuf_fifo.sv
// furv_sbuf_fifo: posted-store FIFO exposing its entries oldest-first for forwarding
module furv_sbuf_fifo
   import furv_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic        pop,
   input  sbuf_entry_t push_entry,
   output logic        full,
   output logic        empty,
   output sbuf_entry_t age_entry [DEPTH],
   output logic [DEPTH-1:0] age_valid
);
   localparam int PW = $clog2(DEPTH);
   sbuf_entry_t mem_q [DEPTH];
   sbuf_entry_t mem_d [DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [PW:0] cnt_q, cnt_d;
   logic do_push, do_pop;
   // A push into a full buffer is accepted only when the head leaves the same cycle
   always_comb begin
      full = cnt_q == (PW+1)'(DEPTH);
      empty = cnt_q == '0;
      do_pop = pop && !empty;
      do_push = push && (!full || do_pop);
      mem_d = mem_q;
      if (do_push) mem_d[tail_q] = push_entry;
      head_d = head_q + PW'(do_pop);
      tail_d = tail_q + PW'(do_push);
      cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
      for (int k = 0; k < DEPTH; k++) begin
         age_entry[k] = mem_q[head_q + PW'(k)];
         age_valid[k] = cnt_q > (PW+1)'(k);
      end
   end
   // Pointers and count reset; entry storage needs none since validity comes from the count
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/furv_dmem_responder.sv
// furv_dmem_responder: word RAM with zero-latency loads and a drained posted store buffer
module furv_dmem_responder
   import furv_pkg::*;
#(
   parameter int AW = 10,
   parameter int DEPTH = 4,
   parameter int WR_LAT = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            mem,
   input  logic            mem_read,
   input  logic [XLEN-1:0] addr,
   inout  wire  [XLEN-1:0] data,
   output logic            sb_full,
   output logic            sb_empty,
   output logic            overflow
);
   localparam int CW = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
   logic [XLEN-1:0] ram_q [2**AW];
   drain_state_t state_q, state_d;
   logic [CW-1:0] ctr_q, ctr_d;
   logic overflow_q, overflow_d;
   logic [AW-1:0] idx;
   logic in_range, store_req, push, pop, full, empty, addr_unused;
   logic [XLEN-1:0] rdata;
   sbuf_entry_t push_entry;
   sbuf_entry_t age_entry [DEPTH];
   logic [DEPTH-1:0] age_valid;
   assign addr_unused = ^addr[1:0];
   assign idx = addr[AW+1:2];
   assign in_range = addr[XLEN-1:AW+2] == '0;
   assign store_req = mem && !mem_read && in_range;
   assign push = store_req && !rst;
   assign pop = state_q == WRITE && ctr_q == '0 && !rst;
   assign push_entry = '{idx: (XLEN-2)'(idx), data: data};
   furv_sbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk(clk),
      .rst(rst),
      .push(push),
      .pop(pop),
      .push_entry(push_entry),
      .full(full),
      .empty(empty),
      .age_entry(age_entry),
      .age_valid(age_valid)
   );
   // Drain FSM: wait WR_LAT-1 cycles, then commit the head; continue while entries remain
   always_comb begin
      state_d = state_q;
      ctr_d = ctr_q;
      overflow_d = overflow_q | (store_req && full && !pop);
      if (state_q == IDLE) begin
         state_d = empty ? IDLE : WRITE;
         ctr_d = CW'(WR_LAT - 1);
      end else if (ctr_q != '0) begin
         ctr_d = ctr_q - 1'b1;
      end else begin
         state_d = age_valid[1] ? WRITE : IDLE;
         ctr_d = CW'(WR_LAT - 1);
      end
   end
   // Drain state, latency counter and sticky overflow flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ctr_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ctr_q <= ctr_d;
         overflow_q <= overflow_d;
      end
   end
   // Commit the head entry to the RAM on the pop edge
   always_ff @(posedge clk) begin
      if (pop) ram_q[age_entry[0].idx[AW-1:0]] <= age_entry[0].data;
   end
   // Load path: youngest matching buffered entry overrides the RAM word
   always_comb begin
      rdata = ram_q[idx];
      for (int k = 0; k < DEPTH; k++)
         if (age_valid[k] && age_entry[k].idx == (XLEN-2)'(idx)) rdata = age_entry[k].data;
      if (!in_range) rdata = '0;
   end
   assign data = (mem && mem_read) ? rdata : 'z;
   assign sb_full = full;
   assign sb_empty = empty && state_q == IDLE;
   assign overflow = overflow_q;
endmodule
